// File: rtl/pulse_meas_pkg.sv
// Shared state encoding and default counter width for the pulse measurement block.
package pulse_meas_pkg;

    localparam int unsigned DefWidth = 16;

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow
    } state_e;

endpackage

// File: rtl/pulse_meas_edge.sv
// Registered copy of the measured input with cke-gated rise/fall detection.
module pulse_meas_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_cke,
    input  logic i_in,
    output logic o_rise,
    output logic o_fall
);

    logic r_last;

    // Resets high so an input already high at release is not taken as a rise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last <= 1'b1;
        end else if (i_cke) begin
            r_last <= i_in;
        end
    end

    assign o_rise = i_in & ~r_last;
    assign o_fall = ~i_in & r_last;

endmodule

// File: rtl/pulse_meas_digital.sv
// Measures high time and period of a digital waveform; results leave on a valid/ready port.
// Define PULSE_MEAS_TIMEOUT_EN to end a phase lasting `timeout` enabled cycles with a timeout result.
module pulse_meas_digital
    import pulse_meas_pkg::*;
#(
    parameter int unsigned width   = DefWidth,
    parameter int unsigned timeout = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cke,
    input  logic             in,
    output logic [width-1:0] high_cnt,
    output logic [width-1:0] period_cnt,
    output logic             ovf,
    output logic             valid,
    input  logic             ready
);

    localparam logic [width-1:0] CntMax = '1;
    localparam logic [width-1:0] CntOne = width'(1);
    localparam logic [width:0]   IncOne = (width+1)'(1);

    state_e           r_state, w_state_d;
    logic [width-1:0] r_hcnt, w_hcnt_d;
    logic [width-1:0] r_lcnt, w_lcnt_d;
    logic             r_sat, w_sat_d;
    logic [width-1:0] r_high, r_period;
    logic             r_ovf, r_valid;
    logic             w_cap, w_cap_ovf;
    logic [width-1:0] w_cap_high, w_cap_period;
    logic             w_rise, w_fall;
    logic [width:0]   w_hinc, w_linc, w_sum;

    pulse_meas_edge u_edge (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_cke  (cke),
        .i_in   (in),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // One extra bit on each sum exposes saturation.
    assign w_hinc = {1'b0, r_hcnt} + IncOne;
    assign w_linc = {1'b0, r_lcnt} + IncOne;
    assign w_sum  = {1'b0, r_hcnt} + {1'b0, r_lcnt};

`ifdef PULSE_MEAS_TIMEOUT_EN
    localparam bit               ToReach = (timeout >> width) == 0;
    localparam logic [width:0]   ToLen   = (width+1)'(timeout);
    localparam logic [width-1:0] ToCnt   = width'(timeout);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (timeout == 0);
`endif

    always_comb begin
        w_state_d    = r_state;
        w_hcnt_d     = r_hcnt;
        w_lcnt_d     = r_lcnt;
        w_sat_d      = r_sat;
        w_cap        = 1'b0;
        w_cap_high   = r_hcnt;
        w_cap_period = w_sum[width] ? CntMax : w_sum[width-1:0];
        w_cap_ovf    = r_sat | w_sum[width];
        if (cke) begin
            unique case (r_state)
                StIdle: begin
                    if (w_rise) begin
                        w_state_d = StHigh;
                        w_hcnt_d  = CntOne;
                        w_lcnt_d  = '0;
                        w_sat_d   = 1'b0;
                    end
                end
                StHigh: begin
                    if (w_fall) begin
                        w_state_d = StLow;
                        w_lcnt_d  = CntOne;
                    end else begin
                        w_hcnt_d = w_hinc[width] ? CntMax : w_hinc[width-1:0];
                        w_sat_d  = r_sat | w_hinc[width];
`ifdef PULSE_MEAS_TIMEOUT_EN
                        if (ToReach && (w_hinc >= ToLen)) begin
                            w_cap        = 1'b1;
                            w_cap_high   = ToCnt;
                            w_cap_period = ToCnt;
                            w_cap_ovf    = 1'b0;
                            w_state_d    = StIdle;
                        end
`endif
                    end
                end
                StLow: begin
                    if (w_rise) begin
                        w_cap     = 1'b1;
                        w_state_d = StHigh;
                        w_hcnt_d  = CntOne;
                        w_lcnt_d  = '0;
                        w_sat_d   = 1'b0;
                    end else begin
                        w_lcnt_d = w_linc[width] ? CntMax : w_linc[width-1:0];
                        w_sat_d  = r_sat | w_linc[width];
`ifdef PULSE_MEAS_TIMEOUT_EN
                        if (ToReach && (w_linc >= ToLen)) begin
                            w_cap        = 1'b1;
                            w_cap_high   = '0;
                            w_cap_period = ToCnt;
                            w_cap_ovf    = 1'b0;
                            w_state_d    = StIdle;
                        end
`endif
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_hcnt   <= '0;
            r_lcnt   <= '0;
            r_sat    <= 1'b0;
            r_high   <= '0;
            r_period <= '0;
            r_ovf    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_hcnt  <= w_hcnt_d;
            r_lcnt  <= w_lcnt_d;
            r_sat   <= w_sat_d;
            if (w_cap) begin
                r_high   <= w_cap_high;
                r_period <= w_cap_period;
                r_ovf    <= w_cap_ovf;
            end
            // A new capture wins over a same-cycle acceptance.
            r_valid <= w_cap | (r_valid & ~ready);
        end
    end

    assign high_cnt   = r_high;
    assign period_cnt = r_period;
    assign ovf        = r_ovf;
    assign valid      = r_valid;

endmodule
